// File: rtl/pong_game_core.sv
// pong_game_core: two-player Pong engine between the VGA sync generator and the RGB DAC.
// Paddles, round 8x8 ball, serve/score/match-end sequencing, all updated once per frame.
//
// state     | meaning
// IDLE      | waiting for start, nothing moves
// SERVE     | ball parked at centre, counting serve frames
// PLAY      | ball in motion, collisions and misses evaluated
// POINT     | one frame: credit scorer, re-centre ball, aim serve at the loser
// GAME_OVER | match won, ball parked, waiting for start
module pong_game_core #(
    parameter int X_MAX        = 639,
    parameter int Y_MAX        = 479,
    parameter int PAD_HEIGHT   = 72,
    parameter int PAD_VELOCITY = 3,
    parameter int PAD_R_X      = 600,
    parameter int PAD_L_X      = 32,
    parameter int BALL_SIZE    = 8,
    parameter int BALL_SPEED   = 2,
    parameter int SERVE_FRAMES = 60,
    parameter int WIN_SCORE    = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  up,
    input  logic [1:0]  down,
    input  logic        start,
    input  logic        video_on,
    input  logic [9:0]  xpos,
    input  logic [9:0]  ypos,
    output logic [11:0] rgb,
    output logic [3:0]  score_r,
    output logic [3:0]  score_l,
    output logic        game_over
);
    typedef enum logic [2:0] {IDLE, SERVE, PLAY, POINT, GAME_OVER} state_t;

    localparam int               CNT_W      = $clog2(SERVE_FRAMES + 1);
    localparam logic [9:0]       BALL_X0    = 10'((X_MAX + 1 - BALL_SIZE) / 2);
    localparam logic [9:0]       BALL_Y0    = 10'((Y_MAX + 1 - BALL_SIZE) / 2);
    localparam logic [9:0]       PAD_Y0     = 10'((Y_MAX + 1 - PAD_HEIGHT) / 2);
    localparam logic [9:0]       BALL_EXT   = 10'(BALL_SIZE - 1);
    localparam logic [9:0]       PAD_EXT    = 10'(PAD_HEIGHT - 1);
    localparam logic [9:0]       PAD_V      = 10'(PAD_VELOCITY);
    localparam logic [9:0]       SPD_P      = 10'(BALL_SPEED);
    localparam logic [9:0]       SPD_N      = 10'd0 - SPD_P;
    localparam logic [3:0]       WIN        = 4'(WIN_SCORE);
    localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);

    state_t           state;
    logic [9:0]       pad_r_t, pad_l_t, ball_x, ball_y, dx, dy;
    logic [CNT_W-1:0] serve_cnt;
    logic             point_right;

    logic       frame_tick;
    logic [9:0] ball_r, ball_b, pad_r_b, pad_l_b;
    logic       hit_top, hit_bot, hit_pad_r, hit_pad_l, miss_l, miss_r;
    logic [9:0] dx_nxt, dy_nxt;
    logic       miss, right_scores;

    assign frame_tick = (ypos == 10'(Y_MAX + 2)) && (xpos == 10'd0);
    assign ball_r     = ball_x + BALL_EXT;
    assign ball_b     = ball_y + BALL_EXT;
    assign pad_r_b    = pad_r_t + PAD_EXT;
    assign pad_l_b    = pad_l_t + PAD_EXT;

    assign hit_top   = ball_y <= SPD_P;
    assign hit_bot   = ball_b >= 10'(Y_MAX - BALL_SPEED);
    assign hit_pad_r = (ball_r >= 10'(PAD_R_X)) && (ball_r <= 10'(PAD_R_X + 3)) &&
                       (ball_b >= pad_r_t) && (ball_y <= pad_r_b);
    assign hit_pad_l = (ball_x >= 10'(PAD_L_X)) && (ball_x <= 10'(PAD_L_X + 3)) &&
                       (ball_b >= pad_l_t) && (ball_y <= pad_l_b);
    assign miss_l    = ball_x <= SPD_P;
    assign miss_r    = ball_r >= 10'(X_MAX - BALL_SPEED);

    // Paddle step: up wins over down, and a step is only taken if it stays on screen.
    function automatic logic [9:0] pad_step(input logic [9:0] top, input logic u, input logic d);
        logic [9:0] nxt;
        nxt = top;
        if (u) begin
            if (top > PAD_V) nxt = top - PAD_V;
        end else if (d) begin
            if (top + PAD_EXT < 10'(Y_MAX - PAD_VELOCITY)) nxt = top + PAD_V;
        end
        return nxt;
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s == WIN) ? s : s + 4'd1;
    endfunction

    // Collision resolution, first match wins; a y bounce defers any paddle check to the next frame.
    always_comb begin
        dx_nxt       = dx;
        dy_nxt       = dy;
        miss         = 1'b0;
        right_scores = 1'b0;
        if (hit_top)        dy_nxt = SPD_P;
        else if (hit_bot)   dy_nxt = SPD_N;
        else if (hit_pad_r) dx_nxt = SPD_N;
        else if (hit_pad_l) dx_nxt = SPD_P;
        else if (miss_l) begin
            miss         = 1'b1;
            right_scores = 1'b1;
        end else if (miss_r) begin
            miss = 1'b1;
        end
    end

    // Game state, motion and scoring, advanced once per frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pad_r_t     <= PAD_Y0;
            pad_l_t     <= PAD_Y0;
            ball_x      <= BALL_X0;
            ball_y      <= BALL_Y0;
            dx          <= SPD_P;
            dy          <= SPD_P;
            serve_cnt   <= '0;
            point_right <= 1'b0;
            score_r     <= 4'd0;
            score_l     <= 4'd0;
            game_over   <= 1'b0;
        end else if (frame_tick) begin
            if (state == SERVE || state == PLAY) begin
                pad_r_t <= pad_step(pad_r_t, up[0], down[0]);
                pad_l_t <= pad_step(pad_l_t, up[1], down[1]);
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= SERVE;
                        score_r   <= 4'd0;
                        score_l   <= 4'd0;
                        serve_cnt <= '0;
                    end
                end
                SERVE: begin
                    ball_x <= BALL_X0;
                    ball_y <= BALL_Y0;
                    if (serve_cnt == SERVE_LAST) begin
                        serve_cnt <= '0;
                        state     <= PLAY;
                    end else begin
                        serve_cnt <= serve_cnt + CNT_W'(1);
                    end
                end
                PLAY: begin
                    if (miss) begin
                        state       <= POINT;
                        point_right <= right_scores;
                    end else begin
                        dx     <= dx_nxt;
                        dy     <= dy_nxt;
                        ball_x <= ball_x + dx_nxt;
                        ball_y <= ball_y + dy_nxt;
                    end
                end
                POINT: begin
                    ball_x <= BALL_X0;
                    ball_y <= BALL_Y0;
                    // The next serve travels toward the player who just lost the point.
                    if (point_right) begin
                        score_r <= sat_inc(score_r);
                        dx      <= SPD_N;
                        if (sat_inc(score_r) == WIN) begin
                            state     <= GAME_OVER;
                            game_over <= 1'b1;
                        end else begin
                            state <= SERVE;
                        end
                    end else begin
                        score_l <= sat_inc(score_l);
                        dx      <= SPD_P;
                        if (sat_inc(score_l) == WIN) begin
                            state     <= GAME_OVER;
                            game_over <= 1'b1;
                        end else begin
                            state <= SERVE;
                        end
                    end
                end
                GAME_OVER: begin
                    if (start) begin
                        state     <= SERVE;
                        score_r   <= 4'd0;
                        score_l   <= 4'd0;
                        serve_cnt <= '0;
                        game_over <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic       in_pad_l, in_pad_r, in_ball_box, ball_on;
    logic [2:0] bx_off, by_off;
    logic [7:0] mask_row;

    assign in_pad_l    = (xpos >= 10'(PAD_L_X)) && (xpos <= 10'(PAD_L_X + 3)) &&
                         (ypos >= pad_l_t) && (ypos <= pad_l_b);
    assign in_pad_r    = (xpos >= 10'(PAD_R_X)) && (xpos <= 10'(PAD_R_X + 3)) &&
                         (ypos >= pad_r_t) && (ypos <= pad_r_b);
    assign in_ball_box = (xpos >= ball_x) && (xpos <= ball_r) && (ypos >= ball_y) && (ypos <= ball_b);
    assign bx_off      = xpos[2:0] - ball_x[2:0];
    assign by_off      = ypos[2:0] - ball_y[2:0];
    assign ball_on     = in_ball_box && mask_row[bx_off];

    // Round ball mask, one 8-bit row per ball line.
    always_comb begin
        mask_row = 8'h00;
        case (by_off)
            3'd0, 3'd7: mask_row = 8'h3C;
            3'd1, 3'd6: mask_row = 8'h7E;
            default:    mask_row = 8'hFF;
        endcase
    end

    // Pixel colour: blanking, then left paddle, right paddle, ball, background.
    always_comb begin
        rgb = 12'h000;
        if (!video_on)               rgb = 12'h000;
        else if (in_pad_l || in_pad_r) rgb = 12'hAAA;
        else if (ball_on)            rgb = 12'hFFF;
        else if (game_over)          rgb = 12'h400;
        else                         rgb = 12'hBAF;
    end
endmodule
